// File: rtl/ccc_clken_pkg.sv
`default_nettype none
//============================================================================
// Module      : ccc_clken_pkg
// Description : Shared types and defaults for the fabric clock-enable
//               generator: divider field type, config and lock FSM state
//               encodings, and the reset divide value.
// Revision    : 1.0 - initial release
//============================================================================
package ccc_clken_pkg;

    // Default divider field width and its value type
    localparam int c_div_w = 5;
    typedef logic [c_div_w-1:0] div_t;

    // Reset divide value (period = value + 1 = 4 cycles)
    localparam div_t c_div_rst = div_t'(3);

    // Configuration write FSM: one shared pending slot
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_t;

    // Lock FSM
    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage : ccc_clken_pkg
`default_nettype wire

// File: rtl/ccc_clken_channel.sv
`default_nettype none
//============================================================================
// Module      : ccc_clken_channel
// Description : One clock-enable channel. A free-running counter wraps at
//               the programmed divide value and emits a one-cycle enable
//               strobe on the wrap. Bypass holds the enable high. A new
//               divide/bypass pair is loaded only when i_apply is high.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_apply         - load i_new_div / i_new_bypass this edge
//               i_new_div       - divide value to load
//               i_new_bypass    - bypass flag to load
//               i_sync          - force phase alignment this edge
//               o_ce            - registered enable strobe
//               o_tc            - channel can accept an apply this edge
// Revision    : 1.0 - initial release
//============================================================================
module ccc_clken_channel #(
    parameter int DIV_W   = 5,
    parameter int DIV_RST = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_apply,
    input  logic [DIV_W-1:0] i_new_div,
    input  logic             i_new_bypass,
    input  logic             i_sync,
    output logic             o_ce,
    output logic             o_tc
);

    localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(DIV_RST);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_bypass;
    logic             r_ce;
    logic             w_wrap;

    // Counter terminal count in divide mode
    assign w_wrap = !r_bypass && (r_cnt == r_div);

    // A bypassed channel has no phase to protect, so it is always ready
    // to take a new setting; otherwise only at the wrap edge.
    assign o_tc = r_bypass | w_wrap;
    assign o_ce = r_ce;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= c_div_rst;
            r_bypass <= 1'b0;
            r_ce     <= 1'b0;
        end else if (i_apply) begin
            // The apply edge is a wrap edge, so the strobe fires as usual
            // and the new period starts from zero.
            r_div    <= i_new_div;
            r_bypass <= i_new_bypass;
            r_cnt    <= '0;
            r_ce     <= 1'b1;
        end else if (r_bypass) begin
            r_cnt <= '0;
            r_ce  <= 1'b1;
        end else if (i_sync || w_wrap) begin
            r_cnt <= '0;
            r_ce  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_ce  <= 1'b0;
        end
    end

endmodule : ccc_clken_channel
`default_nettype wire

// File: rtl/ccc_clken_gen.sv
`default_nettype none
//============================================================================
// Module      : ccc_clken_gen
// Description : NUM_CH runtime-programmable clock-enable strobes from one
//               fabric clock. Configuration writes are held in a single
//               pending slot and applied only at the target channel's
//               terminal count, so ratio changes never produce runt pulses.
//               LOCK asserts once the configuration has been stable for
//               LOCK_CYCLES edges.
// Options     : CCC_CLKEN_SYNC_EN - adds SYNC input that realigns all
//               non-bypassed channel phases.
// Ports       : FAB_CLK, FAB_RESET - clock, synchronous active-high reset
//               CFG_VALID/READY    - config write handshake
//               CFG_CH, CFG_DIV,
//               CFG_BYPASS         - target channel, divide value, bypass
//               CE_OUT             - per-channel registered enable strobes
//               LOCK               - configuration settled
//               CFG_ERR            - one-cycle pulse on out-of-range write
//               SYNC               - phase align (option only)
// Revision    : 1.0 - initial release
//============================================================================
module ccc_clken_gen
    import ccc_clken_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 5,
    parameter int DIV_RST     = int'(c_div_rst),
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                                            FAB_CLK,
    input  logic                                            FAB_RESET,
    input  logic                                            CFG_VALID,
    output logic                                            CFG_READY,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  CFG_CH,
    input  logic [DIV_W-1:0]                                CFG_DIV,
    input  logic                                            CFG_BYPASS,
`ifdef CCC_CLKEN_SYNC_EN
    input  logic                                            SYNC,
`endif
    output logic [NUM_CH-1:0]                               CE_OUT,
    output logic                                            LOCK,
    output logic                                            CFG_ERR
);

    localparam int c_ch_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_lock_w = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_lock_w-1:0] c_lock_max = c_lock_w'(LOCK_CYCLES);
    localparam logic [c_ch_w:0]     c_num_ch   = (c_ch_w + 1)'(NUM_CH);

    cfg_state_t          r_cfg_state;
    logic                r_cfg_ready;
    logic                r_cfg_err;
    logic [c_ch_w-1:0]   r_pend_ch;
    logic [DIV_W-1:0]    r_pend_div;
    logic                r_pend_bypass;

    lock_state_t         r_lock_state;
    logic [c_lock_w-1:0] r_lock_cnt;

    logic [NUM_CH-1:0]   w_tc;
    logic [NUM_CH-1:0]   w_apply;
    logic                w_apply_any;
    logic                w_ch_oor;
    logic                w_take;
    logic                w_accept;
    logic                w_sync;

`ifdef CCC_CLKEN_SYNC_EN
    assign w_sync = SYNC;
`else
    assign w_sync = 1'b0;
`endif

    // Extra MSB keeps the range test meaningful when NUM_CH is a power of 2
    assign w_ch_oor    = ({1'b0, CFG_CH} >= c_num_ch);
    assign w_take      = (r_cfg_state == IDLE) && CFG_VALID && r_cfg_ready;
    assign w_accept    = w_take && !w_ch_oor;
    assign w_apply_any = |w_apply;

    //------------------------------------------------------------------
    // Channels
    //------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_apply[i] = (r_cfg_state == PENDING) &&
                                (r_pend_ch == c_ch_w'(i)) && w_tc[i];

            ccc_clken_channel #(
                .DIV_W   (DIV_W),
                .DIV_RST (DIV_RST)
            ) u_channel (
                .clk          (FAB_CLK),
                .rst          (FAB_RESET),
                .i_apply      (w_apply[i]),
                .i_new_div    (r_pend_div),
                .i_new_bypass (r_pend_bypass),
                .i_sync       (w_sync),
                .o_ce         (CE_OUT[i]),
                .o_tc         (w_tc[i])
            );
        end
    endgenerate

    //------------------------------------------------------------------
    // Configuration FSM
    //------------------------------------------------------------------
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            r_cfg_state   <= IDLE;
            r_cfg_ready   <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_pend_ch     <= '0;
            r_pend_div    <= '0;
            r_pend_bypass <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_cfg_state)
                IDLE: begin
                    r_cfg_ready <= 1'b1;
                    if (w_take) begin
                        if (w_ch_oor) begin
                            // Out-of-range write is consumed and dropped
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_pend_ch     <= CFG_CH;
                            r_pend_div    <= CFG_DIV;
                            r_pend_bypass <= CFG_BYPASS;
                            r_cfg_state   <= PENDING;
                            r_cfg_ready   <= 1'b0;
                        end
                    end
                end
                PENDING: begin
                    if (w_apply_any) begin
                        r_cfg_state <= IDLE;
                        r_cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    r_cfg_state <= IDLE;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    //------------------------------------------------------------------
    // Lock FSM: counts IDLE edges, saturating at LOCK_CYCLES
    //------------------------------------------------------------------
    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET || w_accept) begin
            r_lock_state <= SETTLE;
            r_lock_cnt   <= '0;
        end else if ((r_cfg_state == IDLE) && (r_lock_cnt != c_lock_max)) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
            if (r_lock_cnt == (c_lock_max - 1'b1)) begin
                r_lock_state <= LOCKED;
            end
        end
    end

    assign CFG_READY = r_cfg_ready;
    assign CFG_ERR   = r_cfg_err;
    assign LOCK      = (r_lock_state == LOCKED);

endmodule : ccc_clken_gen
`default_nettype wire

// File: tb/tb_ccc_clken_gen.sv
`default_nettype none
//============================================================================
// Module      : tb_ccc_clken_gen
// Description : Self-checking bench for ccc_clken_gen. A reference model
//               schedules each channel's next strobe as an absolute edge
//               number and tracks the pending write and lock settle start.
// Revision    : 1.0 - initial release
//============================================================================
module tb_ccc_clken_gen;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 5;
    localparam int DIV_RST     = 3;
    localparam int LOCK_CYCLES = 1024;

    logic              FAB_CLK = 1'b0;
    logic              FAB_RESET;
    logic              CFG_VALID;
    logic              CFG_READY;
    logic [1:0]        CFG_CH;
    logic [DIV_W-1:0]  CFG_DIV;
    logic              CFG_BYPASS;
    logic [NUM_CH-1:0] CE_OUT;
    logic              LOCK;
    logic              CFG_ERR;
`ifdef CCC_CLKEN_SYNC_EN
    logic              SYNC;
`endif

    always #5 FAB_CLK = ~FAB_CLK;

    ccc_clken_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DIV_RST     (DIV_RST),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .FAB_CLK    (FAB_CLK),
        .FAB_RESET  (FAB_RESET),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .CFG_CH     (CFG_CH),
        .CFG_DIV    (CFG_DIV),
        .CFG_BYPASS (CFG_BYPASS),
`ifdef CCC_CLKEN_SYNC_EN
        .SYNC       (SYNC),
`endif
        .CE_OUT     (CE_OUT),
        .LOCK       (LOCK),
        .CFG_ERR    (CFG_ERR)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_edge = 0;
    int m_next [NUM_CH];
    int m_per  [NUM_CH];
    bit m_byp  [NUM_CH];
    bit m_ce   [NUM_CH];
    bit m_pend;
    int m_pch;
    int m_pdiv;
    bit m_pbyp;
    bit m_in_rst;
    int m_settle;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s edge=%0d actual=%0h expected=%0h", tag, m_edge, act, exp);
        end
    endtask

    task automatic model_edge();
        bit any_apply;
        bit was_ready;
        bit sync_now;
        m_edge++;
        sync_now = 1'b0;
`ifdef CCC_CLKEN_SYNC_EN
        sync_now = SYNC;
`endif
        if (FAB_RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_per[i]  = DIV_RST + 1;
                m_next[i] = m_edge + DIV_RST + 1;
                m_byp[i]  = 1'b0;
                m_ce[i]   = 1'b0;
            end
            m_pend   = 1'b0;
            m_in_rst = 1'b1;
            m_settle = m_edge;
            m_err    = 1'b0;
            return;
        end
        was_ready = !m_in_rst && !m_pend;
        any_apply = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_pend && m_pch == i && (m_byp[i] || m_next[i] == m_edge)) begin
                m_ce[i]   = 1'b1;
                m_byp[i]  = m_pbyp;
                m_per[i]  = m_pdiv + 1;
                m_next[i] = m_edge + m_per[i];
                any_apply = 1'b1;
            end else if (m_byp[i]) begin
                m_ce[i] = 1'b1;
            end else if (m_next[i] == m_edge || sync_now) begin
                m_ce[i]   = 1'b1;
                m_next[i] = m_edge + m_per[i];
            end else begin
                m_ce[i] = 1'b0;
            end
        end
        if (any_apply) begin
            m_pend   = 1'b0;
            m_settle = m_edge;
        end
        m_err = 1'b0;
        if (was_ready && CFG_VALID) begin
            if (int'(CFG_CH) < NUM_CH) begin
                m_pend = 1'b1;
                m_pch  = int'(CFG_CH);
                m_pdiv = int'(CFG_DIV);
                m_pbyp = CFG_BYPASS;
            end else begin
                m_err = 1'b1;
            end
        end
        m_in_rst = 1'b0;
    endtask

    task automatic check_out();
        logic [NUM_CH-1:0] exp_ce;
        bit exp_lock;
        for (int i = 0; i < NUM_CH; i++) exp_ce[i] = m_ce[i];
        exp_lock = !m_in_rst && !m_pend && ((m_edge - m_settle) >= LOCK_CYCLES);
        chk("ce_out", 32'(CE_OUT), 32'(exp_ce));
        chk("cfg_ready", 32'(CFG_READY), 32'(!m_in_rst && !m_pend));
        chk("lock", 32'(LOCK), 32'(exp_lock));
        chk("cfg_err", 32'(CFG_ERR), 32'(m_err));
    endtask

    task automatic set_idle();
        CFG_VALID  = 1'b0;
        CFG_CH     = '0;
        CFG_DIV    = '0;
        CFG_BYPASS = 1'b0;
`ifdef CCC_CLKEN_SYNC_EN
        SYNC       = 1'b0;
`endif
    endtask

    task automatic set_random();
        CFG_VALID  = ($urandom_range(0, 15) == 0);
        CFG_CH     = 2'($urandom_range(0, 3));
        CFG_DIV    = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 31))
                                                 : DIV_W'($urandom_range(0, 7));
        CFG_BYPASS = ($urandom_range(0, 7) == 0);
`ifdef CCC_CLKEN_SYNC_EN
        SYNC       = ($urandom_range(0, 39) == 0);
`endif
    endtask

    // One clock edge: update model with the inputs present at the edge,
    // check outputs shortly after, then drive the next inputs.
    task automatic step(input bit rnd);
        @(posedge FAB_CLK);
        model_edge();
        #1;
        check_out();
        if (rnd) set_random();
        else     set_idle();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int k = 0; k < n; k++) step(rnd);
    endtask

    task automatic write(input int ch, input int dv, input bit byp);
        CFG_VALID  = 1'b1;
        CFG_CH     = 2'(ch);
        CFG_DIV    = DIV_W'(dv);
        CFG_BYPASS = byp;
        step(1'b0);
    endtask

    initial begin
        set_idle();
        FAB_RESET = 1'b1;
        #2;
        run(3, 1'b0);
        FAB_RESET = 1'b0;
        // Defaults: period 4 on all channels, LOCK at edge 1024
        run(1035, 1'b0);

        // Reset again, then write ch1 div=7 accepted at edge 2
        FAB_RESET = 1'b1;
        run(2, 1'b0);
        FAB_RESET = 1'b0;
        step(1'b0);
        write(1, 7, 1'b0);
        run(1100, 1'b0);

        // Bypass on ch2, then back to divide-by-1
        write(2, 0, 1'b1);
        run(20, 1'b0);
        write(2, 0, 1'b0);
        run(20, 1'b0);

        // Let it lock, then an out-of-range write
        run(1100, 1'b0);
        write(3, 5, 1'b0);
        run(20, 1'b0);

        // Randomised traffic
        set_random();
        run(4000, 1'b1);
        set_idle();
        run(40, 1'b0);

        // Reset while a long write is pending
        write(0, 31, 1'b0);
        run(2, 1'b0);
        FAB_RESET = 1'b1;
        step(1'b0);
        FAB_RESET = 1'b0;
        run(40, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ccc_clken_gen
`default_nettype wire
